spi_controller: RTL and testbench



---
 rtl/spi_controller.sv | 160 ++++++++++++++++
 tb/tb_spi_controller.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI initiator (mode 0, MSB first) issuing 16-bit frames {rw, addr[6:0], data[7:0]}
// to the on-chip SPI register peripheral. A valid/ready request starts a frame and a
// one-cycle rsp_valid pulse reports completion, carrying the read byte for reads.
`timescale 1ns/1ps
module spi_controller #(
  parameter int HALF_PERIOD = 4,  // clk cycles per SCLK phase
  parameter int CS_SETUP    = 4,  // nCS fall to first SCLK rise
  parameter int CS_HOLD     = 4,  // last SCLK fall to nCS rise
  parameter int CS_IDLE     = 4   // nCS high before the response
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  input  logic       cipo
);

  // Out-of-range timing would break the phase counter or the peripheral's synchronisers.
  if (HALF_PERIOD < 3 || HALF_PERIOD > 255 || CS_SETUP < 4 || CS_SETUP > 255 ||
      CS_HOLD < 2 || CS_HOLD > 255 || CS_IDLE < 2 || CS_IDLE > 255) begin : g_param_check
    $fatal(1, "spi_controller: timing parameter outside supported range");
  end

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t      state, state_next;
  logic [7:0]  phase_cnt;
  logic [7:0]  phase_limit;
  logic        phase_done;
  logic [3:0]  bit_cnt;
  logic [15:0] shift_q;
  logic [7:0]  rdata_sh;
  logic        rw_q;
  logic [1:0]  cipo_sync;
  logic        cipo_s;
  logic        accept;

  // Two-flop synchroniser for the asynchronous peripheral data line.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cipo_sync <= 2'b00;
    else        cipo_sync <= {cipo_sync[0], cipo};
  end

  assign cipo_s    = cipo_sync[1];
  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Length of the current timed phase, expressed as terminal count.
  // NOTE: every output of a combinational block gets a default first, otherwise
  // an unlisted path would hold its old value and infer a latch.
  always_comb begin
    phase_limit = 8'd0;
    unique case (state)
      SETUP:   phase_limit = 8'(CS_SETUP - 1);
      SHIFT:   phase_limit = 8'(HALF_PERIOD - 1);
      HOLD:    phase_limit = 8'(CS_HOLD - 1);
      GAP:     phase_limit = 8'(CS_IDLE - 1);
      default: phase_limit = 8'd0;
    endcase
  end

  assign phase_done = (phase_cnt == phase_limit);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state: each timed phase advances when its counter expires; SHIFT
  // leaves only on the falling edge of the sixteenth bit.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   if (phase_done) state_next = SHIFT;
      SHIFT:   if (phase_done && sclk && (bit_cnt == 4'd15)) state_next = HOLD;
      HOLD:    if (phase_done) state_next = GAP;
      GAP:     if (phase_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: phase timing, SCLK/nCS/COPI generation, CIPO capture, response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= 8'd0;
      bit_cnt   <= 4'd0;
      shift_q   <= 16'h0000;
      rdata_sh  <= 8'h00;
      rw_q      <= 1'b0;
      sclk      <= 1'b0;
      ncs       <= 1'b1;
      copi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      if (state == IDLE || phase_done) phase_cnt <= 8'd0;
      else                             phase_cnt <= phase_cnt + 8'd1;

      unique case (state)
        IDLE: begin
          if (accept) begin
            shift_q  <= {req_rw, req_addr, req_rw ? req_wdata : 8'h00};
            rw_q     <= req_rw;
            copi     <= req_rw;
            ncs      <= 1'b0;
            bit_cnt  <= 4'd0;
            rdata_sh <= 8'h00;
          end
        end
        SETUP: begin
          if (phase_done) sclk <= 1'b1;
        end
        SHIFT: begin
          if (phase_done) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              // Bits 8..15 are the data byte; the peripheral drives CIPO then.
              if (bit_cnt[3]) rdata_sh <= {rdata_sh[6:0], cipo_s};
              if (bit_cnt == 4'd15) begin
                copi <= 1'b0;
              end else begin
                copi    <= shift_q[14];
                shift_q <= {shift_q[14:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
        end
        HOLD: begin
          if (phase_done) ncs <= 1'b1;
        end
        GAP: begin
          if (phase_done) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rw_q ? 8'h00 : rdata_sh;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: a behavioural register peripheral on the
// SPI pins, table-driven frames with full waveform checks against the timing
// formulas, a response scoreboard, plus abort, back-to-back and HALF_PERIOD=3 cases.
`timescale 1ns/1ps
module tb_spi_controller;

  localparam int HP        = 4;
  localparam int SU        = 4;
  localparam int HO        = 4;
  localparam int ID        = 4;
  localparam int LAST_FALL = SU + 31 * HP;     // 128
  localparam int NCS_UP    = LAST_FALL + HO;   // 132
  localparam int RSP_AT    = NCS_UP + ID;      // 136

  logic       clk = 1'b0;
  logic       rst_n;

  // Instance A (default timing)
  logic       req_valid, req_ready, req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy, sclk, ncs, copi, cipo;

  // Instance B (HALF_PERIOD = 3)
  logic       req_valid_b, req_ready_b, req_rw_b;
  logic [6:0] req_addr_b;
  logic [7:0] req_wdata_b;
  logic       rsp_valid_b;
  logic [7:0] rsp_rdata_b;
  logic       busy_b, sclk_b, ncs_b, copi_b, cipo_b;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb_q[$];

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t vecs[9];

  spi_controller dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .sclk(sclk), .ncs(ncs), .copi(copi), .cipo(cipo)
  );

  spi_controller #(.HALF_PERIOD(3), .CS_SETUP(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_rw(req_rw_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .busy(busy_b),
    .sclk(sclk_b), .ncs(ncs_b), .copi(copi_b), .cipo(cipo_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Peripheral model on instance A: decodes frames at SCLK rises, applies writes
  // at nCS rise, and drives the read byte on CIPO during the data phase.
  logic [7:0]  regs[128];
  logic [15:0] rx_a = 16'h0;
  logic [15:0] last_frame_a = 16'h0;
  logic [7:0]  hdr_a = 8'h0;
  int          bits_a = 0;
  logic        sclk_pa = 1'b0, ncs_pa = 1'b1;
  always begin
    logic [7:0] rb;
    @(posedge clk); #1;
    if (ncs) begin
      if (!ncs_pa && bits_a == 16) begin
        last_frame_a = rx_a;
        if (rx_a[15]) regs[rx_a[14:8]] = rx_a[7:0];
      end
      bits_a = 0;
      cipo   = 1'b0;
    end else if (sclk && !sclk_pa) begin
      rx_a = {rx_a[14:0], copi};
      bits_a++;
      if (bits_a == 8) hdr_a = rx_a[7:0];
      if (bits_a >= 9 && bits_a <= 16 && !hdr_a[7]) begin
        rb   = regs[hdr_a[6:0]];
        cipo = rb[16 - bits_a];
      end
    end
    sclk_pa = sclk;
    ncs_pa  = ncs;
  end

  // Peripheral model on instance B: only the PWM mode register (addresses 2/3).
  logic [15:0] rx_b = 16'h0;
  logic [15:0] en_pwm_mode_b = 16'h0;
  int          bits_b = 0;
  logic        sclk_pb = 1'b0, ncs_pb = 1'b1;
  always begin
    @(posedge clk); #1;
    if (ncs_b) begin
      if (!ncs_pb && bits_b == 16 && rx_b[15]) begin
        if (rx_b[14:8] == 7'h03) en_pwm_mode_b[15:8] = rx_b[7:0];
        if (rx_b[14:8] == 7'h02) en_pwm_mode_b[7:0]  = rx_b[7:0];
      end
      bits_b = 0;
    end else if (sclk_b && !sclk_pb) begin
      rx_b = {rx_b[14:0], copi_b};
      bits_b++;
    end
    sclk_pb = sclk_b;
    ncs_pb  = ncs_b;
  end

  // Scoreboard: every completion on instance A pops the expected response byte.
  always begin
    logic [7:0] exp_b;
    @(posedge clk); #1;
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_b = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata, exp_b);
      end
    end
  end

  // One frame on instance A with a cycle-by-cycle comparison against the timing formulas.
  task automatic run_frame(input vec_t v, input string tag);
    logic [15:0] fr;
    int n, p, f, es, en, ec, er, eb;
    logic xs, xn, xc;
    fr = {v.rw, v.addr, v.rw ? v.wdata : 8'h00};
    @(negedge clk);
    req_valid = 1'b1; req_rw = v.rw; req_addr = v.addr; req_wdata = v.wdata;
    n = 0;
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    check({tag, "_ready"}, req_ready, 1);
    if (!req_ready) begin req_valid = 1'b0; return; end
    sb_q.push_back(v.exp_rdata);
    @(posedge clk); #1;
    // Inputs after acceptance must have no effect on the frame in flight.
    req_valid = 1'b0; req_rw = ~v.rw; req_addr = ~v.addr; req_wdata = ~v.wdata;
    es = 0; en = 0; ec = 0; er = 0; eb = 0;
    for (int rel = 0; rel <= RSP_AT + 1; rel++) begin
      if (rel > 0) begin @(posedge clk); #1; end
      if (rel < SU) begin p = -1; f = 0; end
      else begin p = (rel - SU) / HP; f = (p + 1) / 2; end
      xs = (p >= 0) && (p <= 30) && (p % 2 == 0);
      xn = (rel >= NCS_UP);
      xc = (f >= 16) ? 1'b0 : fr[15 - f];
      if (sclk !== xs) es++;
      if (ncs !== xn) en++;
      if (copi !== xc) ec++;
      if (rsp_valid !== (rel == RSP_AT)) er++;
      if (busy !== (rel < RSP_AT) || req_ready !== (rel >= RSP_AT)) eb++;
    end
    check({tag, "_sclk_wave_errs"}, es, 0);
    check({tag, "_ncs_wave_errs"}, en, 0);
    check({tag, "_copi_wave_errs"}, ec, 0);
    check({tag, "_rsp_valid_timing_errs"}, er, 0);
    check({tag, "_busy_ready_errs"}, eb, 0);
    check({tag, "_decoded_frame"}, last_frame_a, fr);
  endtask

  initial begin
    int n, cnt, t_rsp, t_rise, t_fall2, last_fall;
    logic sprev;

    vecs[0] = '{rw: 1'b1, addr: 7'h04, wdata: 8'hA5, exp_rdata: 8'h00};
    vecs[1] = '{rw: 1'b0, addr: 7'h02, wdata: 8'hFF, exp_rdata: 8'h3C};
    vecs[2] = '{rw: 1'b0, addr: 7'h04, wdata: 8'h00, exp_rdata: 8'hA5};
    vecs[3] = '{rw: 1'b1, addr: 7'h7F, wdata: 8'h5A, exp_rdata: 8'h00};
    vecs[4] = '{rw: 1'b0, addr: 7'h33, wdata: 8'h00, exp_rdata: 8'h00};
    vecs[5] = '{rw: 1'b0, addr: 7'h7F, wdata: 8'h12, exp_rdata: 8'h5A};
    vecs[6] = '{rw: 1'b0, addr: 7'h10, wdata: 8'h00, exp_rdata: 8'h00};
    vecs[7] = '{rw: 1'b1, addr: 7'h10, wdata: 8'h66, exp_rdata: 8'h00};
    vecs[8] = '{rw: 1'b0, addr: 7'h10, wdata: 8'h00, exp_rdata: 8'h66};

    foreach (regs[i]) regs[i] = 8'h00;
    regs[2] = 8'h3C;

    rst_n = 1'b0;
    req_valid = 1'b0; req_rw = 1'b0; req_addr = 7'h0; req_wdata = 8'h0;
    req_valid_b = 1'b0; req_rw_b = 1'b0; req_addr_b = 7'h0; req_wdata_b = 8'h0;
    cipo = 1'b0; cipo_b = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk, 0);
    check("rst_ncs", ncs, 1);
    check("rst_copi", copi, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    rst_n = 1'b1;

    // Idle for 20 cycles with no request
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (sclk !== 1'b0 || ncs !== 1'b1 || copi !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0)
        cnt++;
    end
    check("idle_outputs_errs", cnt, 0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted mid-frame at E60 (just after SCLK rise 7)
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 7'h10; req_wdata = 8'h77;
    n = 0;
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    check("abort_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("abort_pre_sclk", sclk, 1);
    check("abort_pre_ncs", ncs, 0);
    rst_n = 1'b0;
    #1;
    check("abort_ncs", ncs, 1);
    check("abort_sclk", sclk, 0);
    check("abort_copi", copi, 0);
    check("abort_req_ready", req_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_rsp_rdata", rsp_rdata, 8'h00);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (200) begin @(posedge clk); #1; if (rsp_valid) cnt++; end
    check("abort_no_rsp", cnt, 0);

    for (int i = 6; i < 9; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: req_valid held high across two writes
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 7'h00; req_wdata = 8'hFF;
    n = 0;
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    check("b2b_ready", req_ready, 1);
    sb_q.push_back(8'h00);
    sb_q.push_back(8'h00);
    @(posedge clk); #1;
    req_addr = 7'h01; req_wdata = 8'h0F;
    t_rsp = -1; t_rise = -1; t_fall2 = -1;
    for (int rel = 1; rel < 400 && t_fall2 < 0; rel++) begin
      @(posedge clk); #1;
      if (rsp_valid && t_rsp < 0) t_rsp = rel;
      if (ncs && t_rise < 0) t_rise = rel;
      if (t_rise >= 0 && !ncs && t_fall2 < 0) begin t_fall2 = rel; req_valid = 1'b0; end
    end
    req_valid = 1'b0;
    check("b2b_ncs_rise", t_rise, NCS_UP);
    check("b2b_rsp_time", t_rsp, RSP_AT);
    check("b2b_ncs_fall_at_rsp_edge", t_fall2, t_rsp + 1);
    check("b2b_gap_ge_cs_idle", (t_fall2 - t_rise) >= ID, 1);
    t_rsp = -1;
    for (int rel = 0; rel < 400 && t_rsp < 0; rel++) begin
      @(posedge clk); #1;
      if (rsp_valid) t_rsp = rel;
    end
    check("b2b_second_rsp_time", t_rsp, RSP_AT - 1);
    check("b2b_en_out", {regs[1], regs[0]}, 16'h0FFF);

    // HALF_PERIOD = 3 instance: write 0x81 to address 0x03
    @(negedge clk);
    req_valid_b = 1'b1; req_rw_b = 1'b1; req_addr_b = 7'h03; req_wdata_b = 8'h81;
    n = 0;
    while (!req_ready_b && n < 500) begin @(negedge clk); n++; end
    check("hp3_ready", req_ready_b, 1);
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    last_fall = -1; t_rsp = -1; sprev = sclk_b;
    for (int rel = 1; rel < 300 && t_rsp < 0; rel++) begin
      @(posedge clk); #1;
      if (sprev && !sclk_b) last_fall = rel;
      sprev = sclk_b;
      if (rsp_valid_b) t_rsp = rel;
    end
    check("hp3_last_sclk_fall", last_fall, 4 + 31 * 3);
    check("hp3_rsp_time", t_rsp, 4 + 31 * 3 + 4 + 4);
    check("hp3_rsp_rdata", rsp_rdata_b, 8'h00);
    check("hp3_en_pwm_mode_hi", en_pwm_mode_b[15:8], 8'h81);

    repeat (5) @(posedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
